ov7670_sccb_sequencer: RTL and testbench
========================================

# ov7670_sccb_sequencer

Sequences the OV7670 register-command ROM and serializes each 16-bit command as an SCCB 3-phase write (ID 0x42, register, value) on the camera's SIOC/SIOD pins. It sits between the command ROM (which it drives through `advance`/`resend`) and the camera pads. It signals `done` once the ROM reports its end sentinel. Ownership of the ROM address is exclusive to this block.

## Interface
Parameters:
- `QUARTER` — 250 — clk cycles per SCCB quarter-bit (100 kHz SIOC at 100 MHz clk); minimum 1.
- `RESET_WAIT` — 100000 — extra idle cycles after any write whose command is 16'h1280 (COM7 reset).
- `GAP` — 16 — idle cycles between consecutive writes.
- `AUTO_START` — 1 — if 1, a sequence starts automatically after reset release.

Ports:
- `clk` in 1 — single clock, all logic rising-edge.
- `rst` in 1 — asynchronous, active-high reset.
- `start` in 1 — 1-cycle request to (re)run the whole configuration.
- `command` in 16 — current ROM word {reg, value}; registered by the ROM (2-cycle latency from `advance`/`resend`).
- `finished` in 1 — ROM end sentinel (command == 16'hFFFF).
- `advance` out 1 — 1-cycle pulse: step ROM address.
- `resend` out 1 — 1-cycle pulse: rewind ROM address to 0.
- `sioc` out 1 — SCCB clock level (push-pull).
- `siod_low` out 1 — 1 pulls SIOD low; 0 releases it (pad pull-up gives 1).
- `busy` out 1 — high from sequence start until `done`.
- `done` out 1 — high after the sentinel is reached; cleared by the next start.
- `write_count` out 8 — writes completed in the current sequence; saturates at 255.

## Operation
- Reset values: `sioc`=1, `siod_low`=0, `advance`=0, `resend`=0, `busy`=0, `done`=0, `write_count`=0; state IDLE. Reset asserted mid-transfer aborts at once: the line is released and all outputs return to reset values. No STOP is generated.
- States: IDLE → REWIND → SETTLE → CHECK → START → BITS → STOP → HOLD → STEP → SETTLE …; CHECK → DONE on `finished`.
- IDLE/DONE: `start`, or the first cycle after reset release when AUTO_START=1, → REWIND. In every other state `start` is ignored.
- REWIND: `resend`=1 for one cycle, `write_count` cleared, `done` cleared, `busy` set.
- SETTLE: exactly 2 cycles so `command`/`finished` reflect the new address.
- CHECK (1 cycle): if `finished`=1 → DONE (`busy`=0, `done`=1). Otherwise latch `command` into a shift frame and go to START.
- Frame: 27 bits, MSB first: 0x42, then don't-care bit, then `command[15:8]`, then don't-care bit, then `command[7:0]`, then don't-care bit. For a data bit b, `siod_low`=~b. For a don't-care bit, `siod_low`=0 (released). ACK is not sampled.
- START (2 quarters): q0 `sioc`=1, `siod_low`=1; q1 `sioc`=0, `siod_low`=1.
- BITS (4 quarters per bit): q0–q1 `sioc`=0 with data set at q0; q2–q3 `sioc`=1. Data is never changed while `sioc`=1.
- STOP (4 quarters): q0 `sioc`=0, `siod_low`=1; q1 `sioc`=1, `siod_low`=1; q2–q3 `sioc`=1, `siod_low`=0.
- HOLD: wait GAP cycles, plus RESET_WAIT more if the latched command == 16'h1280. Line idle (`sioc`=1, `siod_low`=0). `write_count` is incremented on entry.
- STEP: `advance`=1 for one cycle → SETTLE.

## Timing
- One write occupies (2+108+4)·QUARTER bus cycles, followed by GAP (+RESET_WAIT) + 1 (STEP) + 2 (SETTLE) + 1 (CHECK) cycles.
- The quarter counter runs from QUARTER−1 down to 0. Phase and bit transitions occur on the terminal count. Bit index runs 26 down to 0 without wrap.
- `advance` and `resend` are never high simultaneously and never high on consecutive cycles.
- `busy` rises the cycle after the REWIND decision. `done` and `busy` change in the same cycle.
- `write_count` saturates at 255; it does not wrap.

## Test plan
- Reset state: QUARTER=2, AUTO_START=0, hold `rst` → all outputs at reset values; deassert with no `start` → no activity for 1000 cycles.
- Single write: ROM model {16'h3A04, 16'hFFFF}, `start` pulse → exactly one `resend`. SIOD sampled on `sioc` rising edges reads 0x42,x,0x3A,x,0x04,x. Then one `advance`, then `done`=1, `write_count`=1.
- Frame shape: check the SIOD fall while `sioc`=1 at START and the SIOD rise while `sioc`=1 at STOP. SIOD is stable whenever `sioc`=1 inside BITS. Each write spans 228 cycles at QUARTER=2.
- COM7 wait: ROM {16'h1280, 16'h1204, 16'hFFFF}, RESET_WAIT=50, GAP=4 → the gap after the first write is 54 cycles; after the second write it is 4 cycles.
- Restart: `start` mid-BITS is ignored. `start` in DONE → `done` drops, `resend` pulses, `write_count`=0, and the sequence replays identically.
- Async abort: assert `rst` mid-BITS between clock edges → `sioc`=1 and `siod_low`=0 immediately, before the next clk edge. With AUTO_START=1 the full sequence reruns from address 0 after release.

Source files
------------

// File: rtl/ov7670_sccb_sequencer.sv
// Walks the OV7670 command ROM and writes each {reg, value} word as a 3-phase SCCB write (ID 0x42).
// All outputs are registered; reset is asynchronous, so the bus is released the instant rst rises.
module ov7670_sccb_sequencer #(
  parameter int unsigned QUARTER    = 250,
  parameter int unsigned RESET_WAIT = 100000,
  parameter int unsigned GAP        = 16,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] command,
  input  logic        finished,
  output logic        advance,
  output logic        resend,
  output logic        sioc,
  output logic        siod_low,
  output logic        busy,
  output logic        done,
  output logic [7:0]  write_count
);

  localparam int unsigned QW         = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int unsigned HOLD_SHORT = (GAP > 0) ? GAP : 1;
  localparam int unsigned HOLD_LONG  = ((GAP + RESET_WAIT) > 0) ? (GAP + RESET_WAIT) : 1;
  localparam int unsigned HW         = $clog2(HOLD_LONG + 1);
  localparam logic [QW-1:0] Q_LAST   = QW'(QUARTER - 1);
  localparam logic [15:0] COM7_RESET = 16'h1280;

  typedef enum logic [3:0] {
    S_IDLE, S_REWIND, S_SETTLE, S_CHECK, S_START,
    S_BITS, S_STOP, S_HOLD, S_STEP, S_DONE
  } state_t;

  state_t         state;
  logic [QW-1:0]  qcnt;
  logic [1:0]     phase;
  logic [4:0]     bit_idx;
  logic [26:0]    frame;
  logic [HW-1:0]  hcnt;
  logic           settle_cnt;
  logic           auto_pend;
  logic           long_hold;
  logic           q_term;

  assign q_term = (qcnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      qcnt        <= '0;
      phase       <= '0;
      bit_idx     <= '0;
      frame       <= '0;
      hcnt        <= '0;
      settle_cnt  <= 1'b0;
      auto_pend   <= AUTO_START;
      long_hold   <= 1'b0;
      advance     <= 1'b0;
      resend      <= 1'b0;
      sioc        <= 1'b1;
      siod_low    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      write_count <= '0;
    end else begin
      auto_pend <= 1'b0;
      advance   <= 1'b0;
      resend    <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start || auto_pend) begin
            state       <= S_REWIND;
            resend      <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            write_count <= '0;
          end
        end

        S_REWIND: begin
          state      <= S_SETTLE;
          settle_cnt <= 1'b0;
        end

        // ROM is registered twice, so give command/finished two cycles to follow the address
        S_SETTLE: begin
          settle_cnt <= 1'b1;
          if (settle_cnt) state <= S_CHECK;
        end

        S_CHECK: begin
          if (finished) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            // Don't-care (ACK) slots hold 1 so the line is released there
            frame     <= {8'h42, 1'b1, command[15:8], 1'b1, command[7:0], 1'b1};
            long_hold <= (command == COM7_RESET);
            state     <= S_START;
            qcnt      <= Q_LAST;
            phase     <= '0;
            sioc      <= 1'b1;
            siod_low  <= 1'b1;
          end
        end

        S_START: begin
          if (q_term) begin
            qcnt <= Q_LAST;
            if (phase == 2'd0) begin
              phase <= 2'd1;
              sioc  <= 1'b0;
            end else begin
              state    <= S_BITS;
              phase    <= '0;
              bit_idx  <= 5'd26;
              siod_low <= ~frame[26];
            end
          end else begin
            qcnt <= qcnt - QW'(1);
          end
        end

        S_BITS: begin
          if (q_term) begin
            qcnt  <= Q_LAST;
            phase <= phase + 2'd1;
            case (phase)
              2'd1:    sioc <= 1'b1;
              2'd3: begin
                sioc <= 1'b0;
                if (bit_idx == 5'd0) begin
                  state    <= S_STOP;
                  siod_low <= 1'b1;
                end else begin
                  bit_idx  <= bit_idx - 5'd1;
                  frame    <= {frame[25:0], 1'b1};
                  siod_low <= ~frame[25];
                end
              end
              default: ;
            endcase
          end else begin
            qcnt <= qcnt - QW'(1);
          end
        end

        S_STOP: begin
          if (q_term) begin
            qcnt  <= Q_LAST;
            phase <= phase + 2'd1;
            case (phase)
              2'd0: sioc     <= 1'b1;
              2'd1: siod_low <= 1'b0;
              2'd3: begin
                state <= S_HOLD;
                hcnt  <= long_hold ? HW'(HOLD_LONG - 1) : HW'(HOLD_SHORT - 1);
                if (write_count != 8'hFF) write_count <= write_count + 8'd1;
              end
              default: ;
            endcase
          end else begin
            qcnt <= qcnt - QW'(1);
          end
        end

        S_HOLD: begin
          if (hcnt == '0) begin
            state   <= S_STEP;
            advance <= 1'b1;
          end else begin
            hcnt <= hcnt - HW'(1);
          end
        end

        S_STEP: begin
          state      <= S_SETTLE;
          settle_cnt <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_sequencer.sv
// Bench for ov7670_sccb_sequencer: ROM models, SCCB frame decoder, scoreboard of expected writes and gaps.
module tb_ov7670_sccb_sequencer;

  localparam int Q  = 2;
  localparam int RW = 50;
  localparam int GP = 4;

  typedef struct {
    logic [27:0] bits;
    int          nbits;
    int          span;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rom [0:3];

  // Instance A: manual start
  logic        rst_a = 1'b1, start_a = 1'b0;
  logic [1:0]  addr_a = 2'd0;
  logic [15:0] command_a = 16'hFFFF;
  logic        finished_a;
  logic        advance_a, resend_a, sioc_a, siod_low_a, busy_a, done_a;
  logic [7:0]  write_count_a;

  // Instance B: auto start, used for the asynchronous abort
  logic        rst_b = 1'b1, start_b = 1'b0;
  logic [1:0]  addr_b = 2'd0;
  logic [15:0] command_b = 16'hFFFF;
  logic        finished_b;
  logic        advance_b, resend_b, sioc_b, siod_low_b, busy_b, done_b;
  logic [7:0]  write_count_b;

  assign finished_a = (command_a == 16'hFFFF);
  assign finished_b = (command_b == 16'hFFFF);

  ov7670_sccb_sequencer #(.QUARTER(Q), .RESET_WAIT(RW), .GAP(GP), .AUTO_START(1'b0)) u_dut (
    .clk(clk), .rst(rst_a), .start(start_a), .command(command_a), .finished(finished_a),
    .advance(advance_a), .resend(resend_a), .sioc(sioc_a), .siod_low(siod_low_a),
    .busy(busy_a), .done(done_a), .write_count(write_count_a));

  ov7670_sccb_sequencer #(.QUARTER(Q), .RESET_WAIT(RW), .GAP(GP), .AUTO_START(1'b1)) u_auto (
    .clk(clk), .rst(rst_b), .start(start_b), .command(command_b), .finished(finished_b),
    .advance(advance_b), .resend(resend_b), .sioc(sioc_b), .siod_low(siod_low_b),
    .busy(busy_b), .done(done_b), .write_count(write_count_b));

  always @(posedge clk) begin
    if (resend_a) addr_a <= 2'd0;
    else if (advance_a) addr_a <= addr_a + 2'd1;
    command_a <= rom[addr_a];
    if (resend_b) addr_b <= 2'd0;
    else if (advance_b) addr_b <= addr_b + 2'd1;
    command_b <= rom[addr_b];
  end

  // Bus monitor for instance A
  logic        siod_a, siod_b;
  assign siod_a = ~siod_low_a;
  assign siod_b = ~siod_low_b;
  int          cyc = 0, t_start = 0, t_stop = 0, nbits = 0;
  int          n_res_a = 0, n_adv_a = 0, pulse_bad = 0, glitch = 0;
  int          n_res_b = 0, n_adv_b = 0, b_starts = 0;
  logic        sioc_p = 1'b1, siod_p = 1'b1, adv_p = 1'b0, res_p = 1'b0;
  logic        sioc_bp = 1'b1, siod_bp = 1'b1;
  logic        in_frame = 1'b0, have_stop = 1'b0;
  logic [27:0] sh = '0;
  frame_t      frame_obs_q[$];
  int          gap_obs_q[$];

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    sioc_p  <= sioc_a;
    siod_p  <= siod_a;
    adv_p   <= advance_a;
    res_p   <= resend_a;
    sioc_bp <= sioc_b;
    siod_bp <= siod_b;
    if (resend_a) n_res_a <= n_res_a + 1;
    if (advance_a) begin
      n_adv_a <= n_adv_a + 1;
      if (have_stop) gap_obs_q.push_back(cyc - t_stop - 2 * Q);
    end
    if ((advance_a && resend_a) || ((advance_a || resend_a) && (adv_p || res_p)))
      pulse_bad <= pulse_bad + 1;
    if (!in_frame) begin
      if (sioc_p && sioc_a && siod_p && !siod_a) begin
        in_frame <= 1'b1;
        nbits    <= 0;
        sh       <= '0;
        t_start  <= cyc;
      end
    end else if (!sioc_p && sioc_a) begin
      sh    <= {sh[26:0], siod_a};
      nbits <= nbits + 1;
    end else if (sioc_p && sioc_a && (siod_p != siod_a)) begin
      if (siod_a) begin
        frame_obs_q.push_back('{bits: sh, nbits: nbits, span: cyc - t_start});
        in_frame  <= 1'b0;
        t_stop    <= cyc;
        have_stop <= 1'b1;
      end else begin
        glitch <= glitch + 1;
      end
    end
    if (resend_b) n_res_b <= n_res_b + 1;
    if (advance_b) n_adv_b <= n_adv_b + 1;
    if (sioc_bp && sioc_b && siod_bp && !siod_b) b_starts <= b_starts + 1;
  end

  int          n_tests = 0, n_fail = 0;
  logic [15:0] exp_cmd_q[$];
  int          exp_gap_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int k = 0;
    while (done_a !== 1'b1 && k < 3000) begin
      tick(1);
      k++;
    end
    check(tag, {31'd0, done_a}, 32'd1);
  endtask

  task automatic push_write(input logic [15:0] cmd, input int gap);
    exp_cmd_q.push_back(cmd);
    exp_gap_q.push_back(gap);
  endtask

  task automatic drain(input string tag);
    frame_t      f;
    logic [15:0] c;
    logic [27:0] e;
    int          g;
    check({tag, "_frame_count"}, frame_obs_q.size(), exp_cmd_q.size());
    while (exp_cmd_q.size() > 0 && frame_obs_q.size() > 0) begin
      c = exp_cmd_q.pop_front();
      f = frame_obs_q.pop_front();
      e = {8'h42, 1'b1, c[15:8], 1'b1, c[7:0], 1'b1, 1'b0};
      check({tag, "_frame_bits"}, {4'd0, f.bits}, {4'd0, e});
      check({tag, "_sioc_rises"}, f.nbits, 28);
      check({tag, "_start_to_stop"}, f.span, (2 + 108 + 2) * Q);
    end
    exp_cmd_q.delete();
    frame_obs_q.delete();
    check({tag, "_gap_count"}, gap_obs_q.size(), exp_gap_q.size());
    while (exp_gap_q.size() > 0 && gap_obs_q.size() > 0) begin
      g = gap_obs_q.pop_front();
      check({tag, "_gap"}, g, exp_gap_q.pop_front());
    end
    exp_gap_q.delete();
    gap_obs_q.delete();
  endtask

  initial begin
    int res0, adv0, k;
    for (int i = 0; i < 4; i++) rom[i] = 16'hFFFF;

    // Reset state
    tick(3);
    check("rst_sioc", {31'd0, sioc_a}, 32'd1);
    check("rst_siod_low", {31'd0, siod_low_a}, 32'd0);
    check("rst_advance", {31'd0, advance_a}, 32'd0);
    check("rst_resend", {31'd0, resend_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_write_count", {24'd0, write_count_a}, 32'd0);
    rst_a = 1'b0;
    tick(1000);
    check("idle_resends", n_res_a, 0);
    check("idle_advances", n_adv_a, 0);
    check("idle_busy", {31'd0, busy_a}, 32'd0);
    check("idle_frames", frame_obs_q.size(), 0);

    // Single write
    rom[0] = 16'h3A04; rom[1] = 16'hFFFF;
    push_write(16'h3A04, GP);
    pulse_start();
    check("go_resend", {31'd0, resend_a}, 32'd1);
    check("go_busy", {31'd0, busy_a}, 32'd1);
    wait_done_a("single_done");
    check("single_resends", n_res_a, 1);
    check("single_advances", n_adv_a, 1);
    check("single_write_count", {24'd0, write_count_a}, 32'd1);
    check("single_busy", {31'd0, busy_a}, 32'd0);
    drain("single");

    // COM7 reset wait, restarted from DONE
    rom[0] = 16'h1280; rom[1] = 16'h1204; rom[2] = 16'hFFFF;
    push_write(16'h1280, GP + RW);
    push_write(16'h1204, GP);
    res0 = n_res_a; adv0 = n_adv_a;
    pulse_start();
    check("restart_done_drop", {31'd0, done_a}, 32'd0);
    check("restart_resend", {31'd0, resend_a}, 32'd1);
    check("restart_write_count", {24'd0, write_count_a}, 32'd0);
    wait_done_a("com7_done");
    check("com7_resends", n_res_a - res0, 1);
    check("com7_advances", n_adv_a - adv0, 2);
    check("com7_write_count", {24'd0, write_count_a}, 32'd2);
    drain("com7");

    // Start during BITS is ignored, sequence replays identically
    push_write(16'h1280, GP + RW);
    push_write(16'h1204, GP);
    res0 = n_res_a;
    pulse_start();
    k = 0;
    while (!(in_frame && nbits >= 5) && k < 500) begin tick(1); k++; end
    check("reach_mid_bits", {31'd0, in_frame}, 32'd1);
    pulse_start();
    check("midbits_busy", {31'd0, busy_a}, 32'd1);
    wait_done_a("replay_done");
    check("replay_resends", n_res_a - res0, 1);
    check("replay_write_count", {24'd0, write_count_a}, 32'd2);
    drain("replay");
    check("pulse_rules", pulse_bad, 0);
    check("siod_stable_sioc_high", glitch, 0);

    // Async abort on auto-start instance
    @(negedge clk); rst_b = 1'b0;
    tick(30);
    check("abort_pre_busy", {31'd0, busy_b}, 32'd1);
    check("abort_pre_starts", b_starts, 1);
    @(posedge clk); #3 rst_b = 1'b1;
    #1;
    check("abort_sioc", {31'd0, sioc_b}, 32'd1);
    check("abort_siod_low", {31'd0, siod_low_b}, 32'd0);
    check("abort_busy", {31'd0, busy_b}, 32'd0);
    tick(4);
    @(negedge clk); rst_b = 1'b0;
    k = 0;
    while (done_b !== 1'b1 && k < 3000) begin tick(1); k++; end
    check("auto_done", {31'd0, done_b}, 32'd1);
    check("auto_resends", n_res_b, 2);
    check("auto_advances", n_adv_b, 2);
    check("auto_starts", b_starts, 3);
    check("auto_write_count", {24'd0, write_count_b}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
